// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter: round-robin arbiter with grant handshake, ownership hold,
// release and hold-timeout for one shared downstream resource.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   request       level requests, bit i = requester i
//   grant_ready   resource accepts the offered grant (sampled in OFFER only)
//   owner_release owner finished, single-cycle pulse (sampled in BUSY only).
//                 "release" is a reserved word in SystemVerilog, hence the name.
//   grant_valid   grant offered or held
//   grant_index   winning requester index
//   grant_onehot  one-hot of grant_index, zero whenever grant_valid is low
//   busy          resource owned (BUSY state)
//   timeout       one-cycle pulse when a grant is revoked by hold timeout
module rr_priority_arbiter #(
    parameter int unsigned NUM_REQ  = 8,
    parameter int unsigned IDX_W    = 3,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] request,
    input  logic               grant_ready,
    input  logic               owner_release,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_index,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic               busy,
    output logic               timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [IDX_W-1:0]    ptr, ptr_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
    logic                grant_valid_n;
    logic [IDX_W-1:0]    grant_index_n;
    logic [NUM_REQ-1:0]  grant_onehot_n;
    logic                busy_n;
    logic                timeout_n;

    logic                win_found;
    logic [IDX_W-1:0]    win_idx;

    logic                owner_drop;
    logic                hold_expired;
    logic                busy_end;
    logic [IDX_W-1:0]    ptr_after;

    // Priority scan starting at ptr, wrapping NUM_REQ-1 -> 0; first set bit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            int unsigned cand;
            cand = 32'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && request[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    assign owner_drop   = !request[grant_index];
    assign hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign busy_end     = owner_release || owner_drop || hold_expired;
    assign ptr_after    = (grant_index == IDX_W'(NUM_REQ - 1)) ? '0 : grant_index + IDX_W'(1);

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n        = state;
        ptr_n          = ptr;
        hold_cnt_n     = hold_cnt;
        grant_valid_n  = grant_valid;
        grant_index_n  = grant_index;
        grant_onehot_n = grant_onehot;
        busy_n         = busy;
        timeout_n      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (win_found) begin
                    state_n        = ST_OFFER;
                    grant_valid_n  = 1'b1;
                    grant_index_n  = win_idx;
                    grant_onehot_n = NUM_REQ'(1) << win_idx;
                end
            end
            ST_OFFER: begin
                // Withdrawal takes precedence over a coincident grant_ready.
                if (owner_drop) begin
                    state_n        = ST_IDLE;
                    grant_valid_n  = 1'b0;
                    grant_index_n  = '0;
                    grant_onehot_n = '0;
                end else if (grant_ready) begin
                    state_n    = ST_BUSY;
                    busy_n     = 1'b1;
                    hold_cnt_n = '0;
                end
            end
            ST_BUSY: begin
                if (busy_end) begin
                    state_n        = ST_IDLE;
                    grant_valid_n  = 1'b0;
                    grant_index_n  = '0;
                    grant_onehot_n = '0;
                    busy_n         = 1'b0;
                    hold_cnt_n     = '0;
                    ptr_n          = ptr_after;
                    // Timeout only when expiry is the sole reason for ending.
                    timeout_n      = hold_expired && !owner_release && !owner_drop;
                end else begin
                    hold_cnt_n = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_n        = ST_IDLE;
                grant_valid_n  = 1'b0;
                grant_index_n  = '0;
                grant_onehot_n = '0;
                busy_n         = 1'b0;
                hold_cnt_n     = '0;
            end
        endcase
    end

    // State, pointer, hold counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            hold_cnt     <= '0;
            grant_valid  <= 1'b0;
            grant_index  <= '0;
            grant_onehot <= '0;
            busy         <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            hold_cnt     <= hold_cnt_n;
            grant_valid  <= grant_valid_n;
            grant_index  <= grant_index_n;
            grant_onehot <= grant_onehot_n;
            busy         <= busy_n;
            timeout      <= timeout_n;
        end
    end

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Sequential round-robin arbiter that shares one downstream resource among NUM_REQ requesters.
- Reuses the priority-encode function (lowest set bit wins) with a rotating start pointer.
- Adds a grant handshake, ownership hold, release and hold-timeout.
- Sits between the request lines and the shared datapath; the datapath consumes grant_index/grant_onehot.

Parameters:
- NUM_REQ, 8, number of requesters; legal 2..16; need not be a power of two.
- IDX_W, 3, grant_index width; must equal clog2(NUM_REQ).
- MAX_HOLD, 16, maximum BUSY cycles per grant; legal 2..255.
- HOLD_W, 8, hold counter width; must hold MAX_HOLD-1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- request  input  NUM_REQ  level requests; bit i = requester i.
- grant_ready  input  1  resource accepts the offered grant.
- release  input  1  owner finished; single-cycle pulse.
- grant_valid  output  1  grant offered or held.
- grant_index  output  IDX_W  winning requester index.
- grant_onehot  output  NUM_REQ  one-hot of grant_index, qualified by grant_valid.
- busy  output  1  resource owned (BUSY state).
- timeout  output  1  one-cycle pulse when a grant is revoked by hold timeout.

Behaviour:
- Reset (async assert, sync deassert by the system): state IDLE, ptr=0, hold_cnt=0, all outputs 0.
- All outputs are registered. grant_onehot is 0 whenever grant_valid=0.
- States: IDLE, OFFER, BUSY.
- Winner selection: scan request from bit ptr upward, wrapping NUM_REQ-1 -> 0. The first set bit wins. The scan is combinational; the result is captured only in IDLE.
- IDLE, request==0: stay in IDLE.
- IDLE, request!=0: capture the winner into grant_index/grant_onehot and go to OFFER. grant_valid=1 from the next cycle, so latency from request to grant_valid is 1 cycle.
- OFFER: grant_index/onehot held stable.
  - grant_ready=1 -> BUSY, busy=1, hold_cnt=0.
  - request[grant_index] drops before grant_ready (withdrawal) -> IDLE, grant_valid=0, ptr unchanged.
  - grant_ready and withdrawal in the same cycle -> withdrawal wins, go to IDLE.
- BUSY: grant_valid=1, busy=1, hold_cnt increments each cycle. End conditions:
  - (a) release=1;
  - (b) request[grant_index]=0;
  - (c) hold_cnt==MAX_HOLD-1.
- On any BUSY end: go to IDLE, grant_valid=0, busy=0, ptr <= (grant_index+1) mod NUM_REQ.
- timeout=1 for one cycle only when (c) fires without (a) or (b) in the same cycle. Release or drop in the same cycle as expiry suppresses timeout.
- At least one IDLE cycle separates consecutive grants. A lone persistent requester is re-granted after that one cycle.
- release outside BUSY is ignored. grant_ready outside OFFER is ignored.
- Request changes while in OFFER or BUSY do not alter grant_index.
- Reset asserted mid-OFFER or mid-BUSY: immediate return to the reset values. No timeout pulse.
- ptr wrap: for NUM_REQ=6, grant_index=5 ends -> ptr=0.
- Fairness: with all requests held continuously, grants rotate 0,1,...,NUM_REQ-1,0,...

Test Plan:
- Reset then request=8'h00 for 10 cycles -> grant_valid=0, busy=0, timeout=0 throughout.
- request=8'h24 at cycle 0 with ptr=0 -> grant_index=2 and grant_onehot=8'h04 at cycle 1. grant_ready at cycle 2 -> busy=1 at cycle 3. release -> IDLE. Next grant is index 5 (ptr=3).
- request=8'hFF held, grant_ready tied high, release one cycle after each BUSY entry -> grant_index sequence 0,1,2,...,7,0; one IDLE gap between grants.
- request=8'h01 held, grant_ready=1, no release -> BUSY for exactly 16 cycles, timeout pulse 1 cycle, then re-grant of index 0 after one IDLE cycle.
- Release coincident with hold_cnt==15 -> return to IDLE, timeout stays 0. Withdrawal in OFFER: request[3] dropped before grant_ready -> IDLE, ptr unchanged, no busy.
- Assert rst in BUSY with grant_index=6 -> all outputs 0 asynchronously. After deassert, request=8'hC0 -> grant_index=6 (ptr reset to 0).
